// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD command constants, cursor tables, state type and
// command-packing helpers for lcd_text_feeder.
// Build option: define LCD_FEEDER_INIT_EN to add the power-on init sequence.
package lcd_pkg;

    // Settle delays in 22.1184 MHz clock cycles
    localparam logic [16:0] DLY_4MS1  = 17'd90685;
    localparam logic [16:0] DLY_100US = 17'd2212;
    localparam logic [16:0] DLY_40US  = 17'd885;
    localparam logic [16:0] DLY_1MS64 = 17'd36275;

    // Register-select values presented to the writer
    localparam logic COMM = 1'b0;
    localparam logic DATA = 1'b1;

    // HD44780 command bytes
    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] ENTR_SET = 8'h06;
    localparam logic [7:0] DISP_SET = 8'h0C;
    localparam logic [7:0] DISP_CLR = 8'h01;

    // Host character classes
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_FIRST = 8'h20;
    localparam logic [7:0] CHR_LAST  = 8'h7E;

    // 4x20 display geometry; rows are not contiguous in DDRAM
    localparam logic [4:0] COL_LAST = 5'd19;
    localparam logic [7:0] ROWBASE [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

`ifdef LCD_FEEDER_INIT_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND, ST_WAIT} state_t;
    localparam state_t     ST_RESET  = ST_INIT;
    localparam logic [2:0] INIT_CMDS = 3'd6;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;
    localparam state_t     ST_RESET  = ST_IDLE;
`endif

    // Packs one writer command as {delay, rs, data}
    function automatic logic [25:0] makeCmd(input logic [16:0] delay,
                                            input logic        rs,
                                            input logic [7:0]  data);
        return {delay, rs, data};
    endfunction

    // Power-on init sequence entry by index
    function automatic logic [25:0] initCmd(input logic [2:0] idx);
        case (idx)
            3'd0:    initCmd = makeCmd(DLY_4MS1,  COMM, FUNC_SET);
            3'd1:    initCmd = makeCmd(DLY_100US, COMM, FUNC_SET);
            3'd2:    initCmd = makeCmd(DLY_40US,  COMM, FUNC_SET);
            3'd3:    initCmd = makeCmd(DLY_40US,  COMM, ENTR_SET);
            3'd4:    initCmd = makeCmd(DLY_40US,  COMM, DISP_SET);
            default: initCmd = makeCmd(DLY_1MS64, COMM, DISP_CLR);
        endcase
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// lcd_char_fifo: 8-bit synchronous character FIFO with first-word
// fall-through read data, registered full flag and sticky overflow flag.
module lcd_char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wrEn,
    input  logic [7:0] i_wrData,
    input  logic       i_rdEn,
    output logic [7:0] o_rdData,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_ovf
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_ovf;
    logic [AW:0]   w_countNext;
    logic          w_push;
    logic          w_pop;

    // A write is judged against the registered full flag, so a same-cycle
    // pop on a full FIFO does not make room for it
    assign w_push   = i_wrEn && !r_full;
    assign w_pop    = i_rdEn && (r_count != '0);
    assign o_rdData = r_mem[r_rdPtr];
    assign o_empty  = (r_count == '0);
    assign o_full   = r_full;
    assign o_ovf    = r_ovf;

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    // Storage array; contents need no reset since count gates reads
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_wrData;
    end

    // Pointers, count and flags; pointers wrap naturally at DEPTH
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= w_countNext;
            r_full  <= (w_countNext == FULL_CNT);
            r_ovf   <= r_ovf | (i_wrEn & r_full);
        end
    end

endmodule

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: turns a host character stream into LCD writer commands,
// tracking the 4x20 cursor and inserting DDRAM address commands on wrap.
// Build option: LCD_FEEDER_INIT_EN adds an INIT state issuing six power-on
// commands before characters are processed.
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        ovf,
    output logic        intr,
    output logic [25:0] din,
    input  logic        ok,
    output logic        busy,
    output logic [1:0]  row,
    output logic [4:0]  col
);

    state_t      r_state;
    state_t      w_stateNext;
    logic [25:0] r_din;
    logic [25:0] w_dinNext;
    logic        r_intr;
    logic        w_intrNext;
    logic [1:0]  r_row;
    logic [1:0]  w_rowNext;
    logic [4:0]  r_col;
    logic [4:0]  w_colNext;
    logic        r_addrPend;
    logic        w_addrPendNext;
    logic        w_pop;
    logic [7:0]  w_fifoData;
    logic        w_fifoEmpty;
`ifdef LCD_FEEDER_INIT_EN
    logic [2:0]  r_initIdx;
    logic [2:0]  w_initIdxNext;
`endif

    lcd_char_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wrEn   (wr_en),
        .i_wrData (wr_data),
        .i_rdEn   (w_pop),
        .o_rdData (w_fifoData),
        .o_empty  (w_fifoEmpty),
        .o_full   (full),
        .o_ovf    (ovf)
    );

    assign intr = r_intr;
    assign din  = r_din;
    assign row  = r_row;
    assign col  = r_col;
    assign busy = (r_state != ST_IDLE) || !w_fifoEmpty;

    // Next-state, command selection and cursor update; a pending address
    // command always wins over popping the next character
    always_comb begin
        w_stateNext    = r_state;
        w_dinNext      = r_din;
        w_intrNext     = 1'b0;
        w_rowNext      = r_row;
        w_colNext      = r_col;
        w_addrPendNext = r_addrPend;
        w_pop          = 1'b0;
`ifdef LCD_FEEDER_INIT_EN
        w_initIdxNext  = r_initIdx;
`endif
        case (r_state)
`ifdef LCD_FEEDER_INIT_EN
            ST_INIT: begin
                w_dinNext     = initCmd(r_initIdx);
                w_intrNext    = 1'b1;
                w_initIdxNext = r_initIdx + 3'd1;
                w_stateNext   = ST_SEND;
            end
`endif
            ST_IDLE: begin
                if (r_addrPend) begin
                    w_dinNext      = makeCmd(DLY_40US, COMM,
                                             ROWBASE[r_row] + {3'b000, r_col});
                    w_intrNext     = 1'b1;
                    w_addrPendNext = 1'b0;
                    w_stateNext    = ST_SEND;
                end else if (!w_fifoEmpty) begin
                    w_pop = 1'b1;
                    if (w_fifoData >= CHR_FIRST && w_fifoData <= CHR_LAST) begin
                        w_dinNext   = makeCmd(DLY_40US, DATA, w_fifoData);
                        w_intrNext  = 1'b1;
                        w_stateNext = ST_SEND;
                        if (r_col == COL_LAST) begin
                            w_colNext      = 5'd0;
                            w_rowNext      = r_row + 2'd1;
                            w_addrPendNext = 1'b1;
                        end else begin
                            w_colNext = r_col + 5'd1;
                        end
                    end else if (w_fifoData == CHR_LF) begin
                        w_colNext      = 5'd0;
                        w_rowNext      = r_row + 2'd1;
                        w_addrPendNext = 1'b1;
                    end else if (w_fifoData == CHR_FF) begin
                        w_dinNext      = makeCmd(DLY_1MS64, COMM, DISP_CLR);
                        w_intrNext     = 1'b1;
                        w_rowNext      = 2'd0;
                        w_colNext      = 5'd0;
                        w_addrPendNext = 1'b0;
                        w_stateNext    = ST_SEND;
                    end
                end
            end
            ST_SEND: w_stateNext = ST_WAIT;
            ST_WAIT: begin
                if (ok) begin
`ifdef LCD_FEEDER_INIT_EN
                    w_stateNext = (r_initIdx < INIT_CMDS) ? ST_INIT : ST_IDLE;
`else
                    w_stateNext = ST_IDLE;
`endif
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RESET;
            r_din      <= '0;
            r_intr     <= 1'b0;
            r_row      <= 2'd0;
            r_col      <= 5'd0;
            r_addrPend <= 1'b0;
`ifdef LCD_FEEDER_INIT_EN
            r_initIdx  <= 3'd0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_din      <= w_dinNext;
            r_intr     <= w_intrNext;
            r_row      <= w_rowNext;
            r_col      <= w_colNext;
            r_addrPend <= w_addrPendNext;
`ifdef LCD_FEEDER_INIT_EN
            r_initIdx  <= w_initIdxNext;
`endif
        end
    end

endmodule
